sipo_deserializer: RTL

SIPO_DESERIALIZER -- requirements
Module: sipo_deserializer

---
 rtl/sipo_deserializer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/sipo_deserializer.sv
// -----------------------------------------------------------------------------
// sipo_deserializer
//
// Purpose:
//   Rebuilds parallel words from a serial bit stream produced by an upstream
//   parallel-to-serial stage. A word starts on the cycle where sync is high
//   (that cycle's sin is bit 0). Each following cycle supplies one more bit.
//   When the last bit arrives, the word is published on q together with a
//   one-cycle valid pulse. If sync is seen again before a word is complete,
//   the partial word is thrown away. This raises a one-cycle err pulse and
//   bumps a saturating abort counter. The new sync still starts a fresh word.
//
// Parameters:
//   WIDTH     - bits per word, 2..16
//   MSB_FIRST - 1: first serial bit lands in q[WIDTH-1]; 0: lands in q[0]
//
// Ports:
//   clk      in   rising-edge clock for all state
//   rst      in   synchronous, active-high reset
//   sin      in   serial data bit
//   sync     in   marks bit 0 of a new word
//   q        out  last completed word (held between valid pulses)
//   valid    out  one-cycle pulse, q has just been updated
//   err      out  one-cycle pulse, a partial word was aborted by sync
//   err_cnt  out  saturating (at 15) count of aborted words
// -----------------------------------------------------------------------------
module sipo_deserializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sync,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  output logic             err,
  output logic [3:0]       err_cnt
);

  // Counter wide enough for 0..WIDTH-1.
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [0:0]    ST_IDLE  = 1'b0;
  localparam logic [0:0]    ST_SHIFT = 1'b1;
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [3:0]    ERR_MAX  = 4'hF;

  logic [0:0]       state_q,   state_d;
  logic [CW-1:0]    cnt_q,     cnt_d;
  logic [WIDTH-1:0] sr_q,      sr_d;
  logic [WIDTH-1:0] word_q,    word_d;
  logic             valid_q,   valid_d;
  logic             err_q,     err_d;
  logic [3:0]       err_cnt_q, err_cnt_d;

  // Places serial bit number pos into its lane of the word. The lane depends
  // on the bit order: MSB-first puts bit 0 at the top of the word.
  function automatic logic [WIDTH-1:0] insert_bit(
    input logic [WIDTH-1:0] word,
    input logic [CW-1:0]    pos,
    input logic             b
  );
    logic [WIDTH-1:0] r;
    int               lane;
    r    = word;
    lane = MSB_FIRST ? (WIDTH - 1 - int'(pos)) : int'(pos);
    for (int i = 0; i < WIDTH; i++) begin
      if (i == lane) begin
        r[i] = b;
      end else begin
        r[i] = word[i];
      end
    end
    return r;
  endfunction

  // Saturating increment of the abort counter.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    if (v == ERR_MAX) begin
      return ERR_MAX;
    end else begin
      return v + 4'd1;
    end
  endfunction

  // Next-state logic: word assembly, completion and abort handling.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    word_d    = word_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (sync) begin
          sr_d    = insert_bit(sr_q, CNT_ZERO, sin);
          cnt_d   = CNT_ONE;
          state_d = ST_SHIFT;
        end else begin
          // Line is idle between words; sin carries nothing useful here.
          state_d = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        if (sync) begin
          // Early sync wins over completion, even on the would-be last bit:
          // the partial word is dropped and the new word starts at bit 0.
          sr_d      = insert_bit(sr_q, CNT_ZERO, sin);
          cnt_d     = CNT_ONE;
          err_d     = 1'b1;
          err_cnt_d = sat_inc(err_cnt_q);
          state_d   = ST_SHIFT;
        end else if (cnt_q == CNT_LAST) begin
          // Last bit goes straight into the published word. This avoids a
          // cycle of delay and lets the next sync follow with no gap.
          sr_d    = insert_bit(sr_q, cnt_q, sin);
          word_d  = insert_bit(sr_q, cnt_q, sin);
          valid_d = 1'b1;
          cnt_d   = CNT_ZERO;
          state_d = ST_IDLE;
        end else begin
          sr_d    = insert_bit(sr_q, cnt_q, sin);
          cnt_d   = cnt_q + CNT_ONE;
          state_d = ST_SHIFT;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // State registers with synchronous reset; reset drops any partial word silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= CNT_ZERO;
      sr_q      <= {WIDTH{1'b0}};
      word_q    <= {WIDTH{1'b0}};
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      word_q    <= word_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign q       = word_q;
  assign valid   = valid_q;
  assign err     = err_q;
  assign err_cnt = err_cnt_q;

endmodule
